// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Pipelined carry-lookahead adder/subtractor with valid/ready handshakes on
//   both sides and C/V/N/Z flags. The operands are split into STAGES segments
//   of SEG = WIDTH/STAGES bits. Each segment is resolved in its own pipeline
//   stage from BLOCK-bit lookahead groups, and the segment carry is registered
//   between stages.
//
//   Optional build macro: CLA_ADDSUB_SAT_EN
//     When defined, a signed overflow clamps the result to the signed limit.
//     flag_v still reports the overflow and flag_c keeps the raw carry.
//
// Ports
//   clk        rising-edge clock
//   clear_n    asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle
//   a, b       operands (WIDTH bits)
//   sub        0 = a+b, 1 = a-b
//   out_valid  result beat valid
//   out_ready  consumer accepts result
//   result     sum/difference (WIDTH bits)
//   flag_c     carry out of the MSB (for subtract, 1 = no borrow)
//   flag_v     signed overflow
//   flag_n     result MSB
//   flag_z     result is zero

module pipelined_cla_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int BLOCK  = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_n,
   output logic             flag_z
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int NGRP = SEG / BLOCK;

   // Adds one segment. Group carries and in-group bit carries are both written
   // as flat sum-of-products expressions, so no carry ripples from one group
   // into the next.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           ci);
      logic [SEG-1:0]  g;
      logic [SEG-1:0]  p;
      logic [SEG-1:0]  cb;
      logic [NGRP-1:0] gg;
      logic [NGRP-1:0] pg;
      logic [NGRP:0]   gc;
      logic            term;
      int              base;
      g  = x & y;
      p  = x ^ y;
      cb = '0;
      gg = '0;
      pg = '0;
      gc = '0;
      for (int grp = 0; grp < NGRP; grp++) begin
         base    = grp * BLOCK;
         gg[grp] = 1'b0;
         pg[grp] = 1'b1;
         for (int i = 0; i < BLOCK; i++) begin
            term = g[base+i];
            for (int m = i + 1; m < BLOCK; m++) term = term & p[base+m];
            gg[grp] = gg[grp] | term;
            pg[grp] = pg[grp] & p[base+i];
         end
      end
      gc[0] = ci;
      for (int j = 0; j < NGRP; j++) begin
         term = ci;
         for (int m = 0; m <= j; m++) term = term & pg[m];
         gc[j+1] = term;
         for (int i = 0; i <= j; i++) begin
            term = gg[i];
            for (int m = i + 1; m <= j; m++) term = term & pg[m];
            gc[j+1] = gc[j+1] | term;
         end
      end
      for (int grp = 0; grp < NGRP; grp++) begin
         base = grp * BLOCK;
         for (int i = 0; i < BLOCK; i++) begin
            term = gc[grp];
            for (int m = 0; m < i; m++) term = term & p[base+m];
            cb[base+i] = term;
            for (int t = 0; t < i; t++) begin
               term = g[base+t];
               for (int m = t + 1; m < i; m++) term = term & p[base+m];
               cb[base+i] = cb[base+i] | term;
            end
         end
      end
      return {gc[NGRP], p ^ cb};
   endfunction

   logic adv;

   // Every stage shifts together on adv; a stalled output freezes the pipe.
   assign adv      = ~(out_valid & ~out_ready);
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // acc_q holds the resolved low sum bits with the not-yet-added upper
      // A segments above them; bop_q holds the conditioned B operand.
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] bop_q;
      logic             carry_q;
      logic             valid_q;

      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] bop_in;
      logic             c_in;
      logic             vld_in;
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] acc_nxt;
      logic [WIDTH-1:0] acc_d;

      if (k == 0) begin : g_first
         assign acc_in = a;
         assign bop_in = sub ? ~b : b;
         assign c_in   = sub;
         assign vld_in = in_valid;
      end else begin : g_next
         assign acc_in = g_stage[k-1].acc_q;
         assign bop_in = g_stage[k-1].bop_q;
         assign c_in   = g_stage[k-1].carry_q;
         assign vld_in = g_stage[k-1].valid_q;
      end

      assign seg_sum = seg_add(acc_in[k*SEG +: SEG], bop_in[k*SEG +: SEG], c_in);

      always_comb begin
         acc_nxt                = acc_in;
         acc_nxt[k*SEG +: SEG]  = seg_sum[SEG-1:0];
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf;
         logic fv_q;
         logic fn_q;
         logic fz_q;

         // acc_in's MSB is still operand A's sign here: the top segment is
         // only overwritten by this stage.
         assign ovf = (acc_in[WIDTH-1] == bop_in[WIDTH-1]) &
                      (acc_nxt[WIDTH-1] != acc_in[WIDTH-1]);

`ifdef CLA_ADDSUB_SAT_EN
         always_comb begin
            acc_d = acc_nxt;
            if (ovf) begin
               acc_d = acc_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign acc_d = acc_nxt;
`endif

         always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n) begin
               fv_q <= 1'b0;
               fn_q <= 1'b0;
               fz_q <= 1'b0;
            end else if (adv) begin
               fv_q <= ovf;
               fn_q <= acc_d[WIDTH-1];
               fz_q <= ~|acc_d;
            end
         end
      end else begin : g_mid
         assign acc_d = acc_nxt;
      end

      always_ff @(posedge clk or negedge clear_n) begin
         if (!clear_n) begin
            acc_q   <= '0;
            bop_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else if (adv) begin
            acc_q   <= acc_d;
            bop_q   <= bop_in;
            carry_q <= seg_sum[SEG];
            valid_q <= vld_in;
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign result    = g_stage[STAGES-1].acc_q;
   assign flag_c    = g_stage[STAGES-1].carry_q;
   assign flag_v    = g_stage[STAGES-1].g_last.fv_q;
   assign flag_n    = g_stage[STAGES-1].g_last.fn_q;
   assign flag_z    = g_stage[STAGES-1].g_last.fz_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

   localparam int W  = 32;
   localparam int ST = 2;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          clear_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          flag_c, flag_v, flag_n, flag_z;

   pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST), .BLOCK(BL)) dut (
      .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n),
      .flag_z(flag_z)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] r;
      logic c, v, n, z;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] r;
      logic c, v, n, z;
   } vec_t;

   exp_t         exp_q[$];
   logic [W-1:0] got_q[$];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
      end
   endtask

   // Reference: exact signed/unsigned arithmetic, then range tests.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t   e;
      longint sx, sy, t, ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      t  = s ? (sx - sy) : (sx + sy);
      e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      e.c = s ? (ux >= uy) : ((ux + uy) > 64'sd4294967295);
      e.r = t[W-1:0];
`ifdef CLA_ADDSUB_SAT_EN
      if (t > 64'sd2147483647)       e.r = 32'h7FFF_FFFF;
      else if (t < -64'sd2147483648) e.r = 32'h8000_0000;
`endif
      e.n = e.r[W-1];
      e.z = (e.r == '0);
      return e;
   endfunction

   // Scoreboard: decided at negedge, which is what the next posedge sees.
   always @(negedge clk) begin
      if (clear_n) begin
         if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
         if (out_valid && out_ready) begin
            exp_t e;
            got_q.push_back(result);
            if (exp_q.size() == 0) begin
               chk("spurious_output", {63'd0, out_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result_flags", {28'd0, result, flag_c, flag_v, flag_n, flag_z},
                   {28'd0, e.r, e.c, e.v, e.n, e.z});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[8];
   int   lat;
   int   waitc;

   initial begin
      vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef CLA_ADDSUB_SAT_EN
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
`else
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
      vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_result_flags", {28'd0, result, flag_c, flag_v, flag_n, flag_z}, 64'd0);
      @(negedge clk);
      clear_n = 1'b1;

      // Directed vectors, one at a time, with latency measurement
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         a = vecs[i].a; b = vecs[i].b; sub = vecs[i].s;
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         chk($sformatf("vec%0d_latency", i), lat, ST);
         chk($sformatf("vec%0d_result_flags", i),
             {28'd0, result, flag_c, flag_v, flag_n, flag_z},
             {28'd0, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z});
      end
      @(posedge clk); #1;

      // Back-pressure: 1+1, 2+2, 3+3 with a 3-cycle stall on the first result
      got_q.delete();
      sub = 1'b0; out_ready = 1'b1;
      a = 32'd1; b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      a = 32'd3; b = 32'd3;
      chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_first_result", {32'd0, result}, 64'd2);
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
      for (int h = 0; h < 3; h++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold_result", {32'd0, result}, 64'd2);
         chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitc = 0;
      while (got_q.size() < 3 && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("bp_count", got_q.size(), 3);
      if (got_q.size() >= 3) begin
         chk("bp_order0", {32'd0, got_q[0]}, 64'd2);
         chk("bp_order1", {32'd0, got_q[1]}, 64'd4);
         chk("bp_order2", {32'd0, got_q[2]}, 64'd6);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_extra", got_q.size(), 3);

      // Async reset with two beats in flight
      out_ready = 1'b0;
      a = 32'd10; b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd30; b = 32'd40;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ar_inflight_valid", {63'd0, out_valid}, 64'd1);
      #1 clear_n = 1'b0;
      #1;
      chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_result_flags", {28'd0, result, flag_c, flag_v, flag_n, flag_z}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      #1 clear_n = 1'b1;
      exp_q.delete();
      got_q.delete();
      out_ready = 1'b1;
      for (int h = 0; h < 4; h++) begin
         @(posedge clk); #1;
         chk("ar_no_stale", {63'd0, out_valid}, 64'd0);
      end

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(9) < 7);
         out_ready = ($urandom_range(9) < 7);
         sub       = $urandom_range(1);
         a         = $urandom;
         b         = $urandom;
         case ($urandom_range(3))
            0: a = ($urandom_range(1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            1: b = ($urandom_range(1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            default: ;
         endcase
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      waitc = 0;
      while ((exp_q.size() != 0 || out_valid) && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("rand_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
